dds_sweep_ctrl: RTL and testbench

- Sequences the `dds` phase-accumulator core through a stepped linear frequency sweep.
- Drives the core's FreqWord and ClkEn from a latched configuration: start word, stop word, step size, dwell time and repeat mode.
- Sits between the control/register logic and the `dds` instance in the ADDA_FIR signal path.
- Supports up-sweeps, down-sweeps, single-shot and continuous (repeating) operation.

---
 rtl/dds_sweep_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
// Steps the dds phase-accumulator core through a linear frequency sweep.
// Configuration is captured on an accepted start and held for the whole sweep.
// Each frequency word is held for max(dwell,1) clocks. The final step is clamped
// onto the stop word. Sweeps are single-shot, or they repeat from the start word.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          one-cycle sweep request, honoured only in IDLE
//   abort_i          terminates a running sweep (no done/wrap pulse)
//   cfg_start_fw_i   first frequency word
//   cfg_stop_fw_i    last frequency word
//   cfg_step_fw_i    unsigned step magnitude
//   cfg_dwell_i      clocks per frequency (0 behaves as 1)
//   cfg_repeat_i     1 = restart at start word after stop, 0 = single shot
//   freq_word_o      dds FreqWord
//   clk_en_o         dds ClkEn
//   busy_o           high while running
//   done_o           one-cycle pulse when a single-shot sweep completes
//   wrap_o           one-cycle pulse on each repeat restart
module dds_sweep_ctrl #(
  parameter int PHASE_W = 24,
  parameter int DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [PHASE_W-1:0] cfg_start_fw_i,
  input  logic [PHASE_W-1:0] cfg_stop_fw_i,
  input  logic [PHASE_W-1:0] cfg_step_fw_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  input  logic               cfg_repeat_i,
  output logic [PHASE_W-1:0] freq_word_o,
  output logic               clk_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               wrap_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] start_fw_q, start_fw_d;
  logic [PHASE_W-1:0] stop_fw_q, stop_fw_d;
  logic [PHASE_W-1:0] step_fw_q, step_fw_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               repeat_q, repeat_d;
  logic               dir_down_q, dir_down_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [PHASE_W-1:0] freq_q, freq_d;
  logic               clk_en_q, clk_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;

  // One extra bit keeps the carry/borrow so the clamp can catch wrap-around.
  logic [PHASE_W:0]   sum_w;
  logic [PHASE_W:0]   diff_w;
  logic [PHASE_W-1:0] next_fw;
  logic               dwell_end;

  assign sum_w  = {1'b0, freq_q} + {1'b0, step_fw_q};
  assign diff_w = {1'b0, freq_q} - {1'b0, step_fw_q};

  // Clamp to the stop word whenever the step would reach or pass it.
  always_comb begin
    next_fw = stop_fw_q;
    if (dir_down_q) begin
      if (!diff_w[PHASE_W] && (diff_w[PHASE_W-1:0] > stop_fw_q)) begin
        next_fw = diff_w[PHASE_W-1:0];
      end
    end else begin
      if (!sum_w[PHASE_W] && (sum_w[PHASE_W-1:0] < stop_fw_q)) begin
        next_fw = sum_w[PHASE_W-1:0];
      end
    end
  end

  // dwell_q already holds max(cfg_dwell,1), so this never underflows.
  assign dwell_end = (cnt_q == (dwell_q - DWELL_W'(1)));

  always_comb begin
    state_d    = state_q;
    start_fw_d = start_fw_q;
    stop_fw_d  = stop_fw_q;
    step_fw_d  = step_fw_q;
    dwell_d    = dwell_q;
    repeat_d   = repeat_q;
    dir_down_d = dir_down_q;
    cnt_d      = cnt_q;
    freq_d     = freq_q;
    clk_en_d   = clk_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          start_fw_d = cfg_start_fw_i;
          stop_fw_d  = cfg_stop_fw_i;
          step_fw_d  = cfg_step_fw_i;
          dwell_d    = (cfg_dwell_i == '0) ? DWELL_W'(1) : cfg_dwell_i;
          repeat_d   = cfg_repeat_i;
          dir_down_d = (cfg_start_fw_i > cfg_stop_fw_i);
          cnt_d      = '0;
          freq_d     = cfg_start_fw_i;
          clk_en_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          cnt_d    = '0;
          freq_d   = '0;
          clk_en_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (dwell_end) begin
          cnt_d = '0;
          if (freq_q == stop_fw_q) begin
            if (repeat_q) begin
              freq_d = start_fw_q;
              wrap_d = 1'b1;
            end else begin
              freq_d   = '0;
              clk_en_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            freq_d = next_fw;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      start_fw_q <= '0;
      stop_fw_q  <= '0;
      step_fw_q  <= '0;
      dwell_q    <= '0;
      repeat_q   <= 1'b0;
      dir_down_q <= 1'b0;
      cnt_q      <= '0;
      freq_q     <= '0;
      clk_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_fw_q <= start_fw_d;
      stop_fw_q  <= stop_fw_d;
      step_fw_q  <= step_fw_d;
      dwell_q    <= dwell_d;
      repeat_q   <= repeat_d;
      dir_down_q <= dir_down_d;
      cnt_q      <= cnt_d;
      freq_q     <= freq_d;
      clk_en_q   <= clk_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
    end
  end

  assign freq_word_o = freq_q;
  assign clk_en_o    = clk_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: table-driven per-cycle vectors plus a
// hand-written asynchronous reset sequence.
module tb_dds_sweep_ctrl;

  localparam int PW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstN;
  logic          startIn;
  logic          abortIn;
  logic [PW-1:0] cfgStart;
  logic [PW-1:0] cfgStop;
  logic [PW-1:0] cfgStep;
  logic [DW-1:0] cfgDwell;
  logic          cfgRepeat;
  logic [PW-1:0] freqWord;
  logic          clkEn;
  logic          busy;
  logic          done;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.PHASE_W(PW), .DWELL_W(DW)) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .start_i        (startIn),
    .abort_i        (abortIn),
    .cfg_start_fw_i (cfgStart),
    .cfg_stop_fw_i  (cfgStop),
    .cfg_step_fw_i  (cfgStep),
    .cfg_dwell_i    (cfgDwell),
    .cfg_repeat_i   (cfgRepeat),
    .freq_word_o    (freqWord),
    .clk_en_o       (clkEn),
    .busy_o         (busy),
    .done_o         (done),
    .wrap_o         (wrap)
  );

  // One record = inputs applied before an edge and outputs expected after it.
  typedef struct {
    logic          start;
    logic          abort;
    logic [PW-1:0] cStart;
    logic [PW-1:0] cStop;
    logic [PW-1:0] cStep;
    logic [DW-1:0] cDwell;
    logic          cRep;
    logic [PW-1:0] eFreq;
    logic          eBusy;
    logic          eDone;
    logic          eWrap;
  } vec_t;

  vec_t vecs[$];

  logic [PW-1:0] fStart, fStop, fStep;
  logic [DW-1:0] fDwell;
  logic          fRep;

  // clk_en is expected to mirror busy in every vector.
  function automatic void addVec(input logic st, input logic ab, input logic [PW-1:0] ef,
                                 input logic eb, input logic edn, input logic ew);
    vec_t v;
    v.start  = st;
    v.abort  = ab;
    v.cStart = fStart;
    v.cStop  = fStop;
    v.cStep  = fStep;
    v.cDwell = fDwell;
    v.cRep   = fRep;
    v.eFreq  = ef;
    v.eBusy  = eb;
    v.eDone  = edn;
    v.eWrap  = ew;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWord(input string name, input int idx, input logic [PW-1:0] act,
                           input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d actual 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d actual %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    startIn   = v.start;
    abortIn   = v.abort;
    cfgStart  = v.cStart;
    cfgStop   = v.cStop;
    cfgStep   = v.cStep;
    cfgDwell  = v.cDwell;
    cfgRepeat = v.cRep;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkWord("freq_word", idx, freqWord, v.eFreq);
    checkBit("clk_en", idx, clkEn, v.eBusy);
    checkBit("busy", idx, busy, v.eBusy);
    checkBit("done", idx, done, v.eDone);
    checkBit("wrap", idx, wrap, v.eWrap);
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i], i);
    end
  endtask

  int s1First, s1Last;

  initial begin
    // Up-sweep 100..400 step 100, dwell 3, single shot.
    s1First = vecs.size();
    fStart = 24'd100; fStop = 24'd400; fStep = 24'd100; fDwell = 16'd3; fRep = 1'b0;
    for (int k = 0; k < 12; k++) addVec(k == 0, 1'b0, PW'(100 + 100 * (k / 3)), 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    s1Last = vecs.size() - 1;

    // Down-sweep with clamped last step, dwell 1.
    fStart = 24'd1000; fStop = 24'd10; fStep = 24'd300; fDwell = 16'd1; fRep = 1'b0;
    addVec(1'b1, 1'b0, 24'd1000, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 24'd700,  1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 24'd400,  1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 24'd100,  1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 24'd10,   1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, '0,       1'b0, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, '0,       1'b0, 1'b0, 1'b0);

    // Up-sweep near the top of the range: the carry must clamp, not wrap to 0.
    fStart = 24'hFFFF00; fStop = 24'hFFFFFF; fStep = 24'h80; fDwell = 16'd1; fRep = 1'b0;
    addVec(1'b1, 1'b0, 24'hFFFF00, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 24'hFFFF80, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, '0,         1'b0, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, '0,         1'b0, 1'b0, 1'b0);

    // Repeat 5..15 step 5 dwell 2: wrap every 6 clocks, then abort, no done.
    fStart = 24'd5; fStop = 24'd15; fStep = 24'd5; fDwell = 16'd2; fRep = 1'b1;
    for (int k = 0; k < 20; k++)
      addVec(k == 0, 1'b0, PW'(5 + 5 * ((k / 2) % 3)), 1'b1, 1'b0, (k > 0) && (k % 6 == 0));
    addVec(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Dwell 0 behaves as 1; start == stop gives one dwell then done.
    fStart = 24'd42; fStop = 24'd42; fStep = 24'd1; fDwell = 16'd0; fRep = 1'b0;
    addVec(1'b1, 1'b0, 24'd42, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, '0,     1'b0, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, '0,     1'b0, 1'b0, 1'b0);

    // Zero step with start != stop never advances; ends only on abort.
    fStart = 24'd7; fStop = 24'd9; fStep = 24'd0; fDwell = 16'd2; fRep = 1'b0;
    for (int k = 0; k < 10; k++) addVec(k == 0, 1'b0, 24'd7, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // start together with abort in IDLE is ignored.
    fStart = 24'd50; fStop = 24'd60; fStep = 24'd5; fDwell = 16'd1; fRep = 1'b0;
    addVec(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // start plus changed cfg during RUN must not disturb the latched sweep.
    fStart = 24'd100; fStop = 24'd300; fStep = 24'd100; fDwell = 16'd2; fRep = 1'b0;
    addVec(1'b1, 1'b0, 24'd100, 1'b1, 1'b0, 1'b0);
    fStart = 24'd999; fStop = 24'd5; fStep = 24'd1; fDwell = 16'd7; fRep = 1'b1;
    addVec(1'b1, 1'b0, 24'd100, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 24'd200, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 24'd200, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 24'd300, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 24'd300, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, '0,      1'b0, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, '0,      1'b0, 1'b0, 1'b0);

    // start == stop with repeat: wrap every dwell; abort on a wrap edge suppresses it.
    fStart = 24'd20; fStop = 24'd20; fStep = 24'd3; fDwell = 16'd2; fRep = 1'b1;
    addVec(1'b1, 1'b0, 24'd20, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 24'd20, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 24'd20, 1'b1, 1'b0, 1'b1);
    addVec(1'b0, 1'b0, 24'd20, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 24'd20, 1'b1, 1'b0, 1'b1);
    addVec(1'b0, 1'b0, 24'd20, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b1, '0,     1'b0, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, '0,     1'b0, 1'b0, 1'b0);

    // Reset state.
    rstN = 1'b0;
    applyStimulus(vecs[0]);
    startIn = 1'b0;
    tick();
    tick();
    checkWord("reset_freq", -1, freqWord, '0);
    checkBit("reset_clk_en", -1, clkEn, 1'b0);
    checkBit("reset_busy", -1, busy, 1'b0);
    checkBit("reset_done", -1, done, 1'b0);
    checkBit("reset_wrap", -1, wrap, 1'b0);
    rstN = 1'b1;
    tick();

    runVectors(0, vecs.size() - 1);

    // Async reset mid-dwell, away from any clock edge.
    runVectors(s1First, s1First + 4);
    #3;
    rstN = 1'b0;
    #1;
    checkWord("async_rst_freq", -2, freqWord, '0);
    checkBit("async_rst_clk_en", -2, clkEn, 1'b0);
    checkBit("async_rst_busy", -2, busy, 1'b0);
    checkBit("async_rst_done", -2, done, 1'b0);
    tick();
    checkBit("held_rst_done", -3, done, 1'b0);
    checkBit("held_rst_busy", -3, busy, 1'b0);
    rstN = 1'b1;
    tick();
    runVectors(s1First, s1Last);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
